// File: rtl/afu_cls_pkg.sv
// Shared layout constants for the classification AFU result cacheline.
// Both the AFU-side packer and the host-side unpacker import this package.
package afu_cls_pkg;

    // Tree cores per beat, as a power of two.
    localparam int CORE_NUM_BITS = 3;
    localparam int CORE_NUM = 1 << CORE_NUM_BITS;

    // Significant bits of each 16-bit result field.
    localparam int TREE_LEVEL = 10;

    // Filler word in every unused 16-bit slot of a cacheline.
    localparam logic [15:0] PAD_WORD = 16'h1313;

    // Cacheline layout.
    localparam int RESULT_FIELD_W = 16;
    localparam int HALF_W = CORE_NUM * RESULT_FIELD_W;
    localparam int DATA_W = 2 * HALF_W;
    localparam int LINE_W = 512;
    localparam int PAD_W = LINE_W - DATA_W;
    localparam int PAD_SLOTS = PAD_W / RESULT_FIELD_W;
    localparam int HI_W = RESULT_FIELD_W - TREE_LEVEL;

    // Packed index bus: one TREE_LEVEL-wide index per core.
    localparam int IDX_W = CORE_NUM * TREE_LEVEL;

    // Reader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT0 = 3'd3,
        ST_EMIT1 = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/afu_result_unpacker.sv
// Pops packed result cachelines from the AFU output FIFO and streams them
// as two beats of per-core tree indices, with line counting and error flags.
module afu_result_unpacker
    import afu_cls_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       ctx_length,
    input  logic              rxq_output_empty,
    output logic              rxq_re,
    input  logic [LINE_W-1:0] rxq_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_beat,
    output logic [31:0]       cl_count,
    output logic              done,
    output logic              pad_err,
    output logic              hi_err
);

    state_t state_q;
    state_t state_d;

    logic [31:0]     len_r;
    logic [31:0]     cl_count_q;
    logic [31:0]     cl_count_inc;
    logic [DATA_W-1:0] line_r;
    logic            pad_err_q;
    logic            hi_err_q;

    logic            start_ok;
    logic            emit1_fire;
    logic            last_line;
    logic            line_pad_bad;
    logic            line_hi_bad;
    logic [2*CORE_NUM-1:0] field_hi;
    logic [HALF_W-1:0] half;

    // A start is only honoured when no line is in flight.
    assign start_ok = start &
                      ((state_q == ST_IDLE) | (state_q == ST_DONE));

    assign cl_count_inc = cl_count_q + 32'd1;
    assign last_line    = (cl_count_inc == len_r);
    assign emit1_fire   = (state_q == ST_EMIT1) & out_ready;

    // Malformed-line detection on the raw FIFO word.
    assign line_pad_bad = rxq_dout[LINE_W-1:DATA_W] !=
                          {PAD_SLOTS{PAD_WORD}};

    for (genvar k = 0; k < 2 * CORE_NUM; k++) begin : g_hi
        assign field_hi[k] =
            |rxq_dout[k*RESULT_FIELD_W+TREE_LEVEL +: HI_W];
    end

    assign line_hi_bad = |field_hi;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (ctx_length == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (!rxq_output_empty) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_EMIT0;
            end
            ST_EMIT0: begin
                if (out_ready) begin
                    state_d = ST_EMIT1;
                end
            end
            ST_EMIT1: begin
                if (out_ready) begin
                    if (last_line) begin
                        state_d = ST_DONE;
                    end else if (!rxq_output_empty) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore/Mealy outputs; the EMIT1 read is a prefetch of the next line.
    always_comb begin
        rxq_re    = 1'b0;
        out_valid = 1'b0;
        out_beat  = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                rxq_re = ~rxq_output_empty;
            end
            ST_EMIT0: begin
                out_valid = 1'b1;
            end
            ST_EMIT1: begin
                out_valid = 1'b1;
                out_beat  = 1'b1;
                rxq_re    = out_ready & ~last_line &
                            ~rxq_output_empty;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                rxq_re = 1'b0;
            end
        endcase
    end

    // Job length latched on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r <= 32'd0;
        end else if (start_ok) begin
            len_r <= ctx_length;
        end
    end

    // Count of cachelines whose second beat has been accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cl_count_q <= 32'd0;
        end else if (start_ok) begin
            cl_count_q <= 32'd0;
        end else if (emit1_fire) begin
            cl_count_q <= cl_count_inc;
        end
    end

    // Line register: data half of the word popped one cycle earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_r <= '0;
        end else if (state_q == ST_WAIT) begin
            line_r <= rxq_dout[DATA_W-1:0];
        end
    end

    // Sticky error flags, cleared only by an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_err_q <= 1'b0;
            hi_err_q  <= 1'b0;
        end else if (start_ok) begin
            pad_err_q <= 1'b0;
            hi_err_q  <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            pad_err_q <= pad_err_q | line_pad_bad;
            hi_err_q  <= hi_err_q | line_hi_bad;
        end
    end

    // Half select follows the beat so data stays stable under stall.
    assign half = out_beat ? line_r[DATA_W-1:HALF_W]
                           : line_r[HALF_W-1:0];

    // Drop the upper bits of each field; they only feed hi_err.
    for (genvar k = 0; k < CORE_NUM; k++) begin : g_idx
        assign out_idx[k*TREE_LEVEL +: TREE_LEVEL] =
            half[k*RESULT_FIELD_W +: TREE_LEVEL];
    end

    assign cl_count = cl_count_q;
    assign pad_err  = pad_err_q;
    assign hi_err   = hi_err_q;

endmodule
